// File: rtl/square_select_ctrl.sv
// Tic-tac-toe square selection: turns mouse clicks on a 3x3 screen grid into
// alternating blue/yellow marks and reports win/draw.
module square_select_ctrl #(
    parameter bit FIRST_PLAYER = 1'b0,
    parameter int MOUSE_W      = 12
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [MOUSE_W-1:0] mouse_xpos,
    input  logic [MOUSE_W-1:0] mouse_ypos,
    input  logic               mouse_left,
    input  logic               start_en,
    input  logic               choice_en,
    input  logic               new_game,
    output logic [8:0]         square,
    output logic [8:0]         square_color,
    output logic               turn,
    output logic               game_over,
    output logic [1:0]         winner
);

    typedef enum logic [2:0] {IDLE, WAIT_CLICK, DECODE, PLACE, CHECK, OVER} state_t;

    // Row, column and diagonal masks over the row-major board.
    localparam logic [8:0] LINES [8] = '{
        9'b000000111, 9'b000111000, 9'b111000000,
        9'b001001001, 9'b010010010, 9'b100100100,
        9'b100010001, 9'b001010100
    };

    state_t             state_q, state_d;
    logic               mouse_left_q, mouse_left_d;
    logic [MOUSE_W-1:0] x_q, x_d, y_q, y_d;
    logic [3:0]         idx_q, idx_d;
    logic [8:0]         square_q, square_d, color_q, color_d;
    logic               turn_q, turn_d, game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;

    logic        click, accept;
    logic [31:0] x_ext, y_ext;
    logic        col_ok, row_ok;
    logic [1:0]  col_sel, row_sel;
    logic [3:0]  dec_idx;
    logic [7:0]  line_blue, line_yellow;
    logic        blue_win, yellow_win;

    assign mouse_left_d = mouse_left;
    assign click        = mouse_left & ~mouse_left_q;
    assign accept       = click & ~choice_en;

    // Grid decode of the coordinates latched at the click; gaps are grid lines.
    always_comb begin
        x_ext   = 32'(x_q);
        y_ext   = 32'(y_q);
        col_ok  = 1'b1;
        col_sel = 2'd0;
        if (x_ext <= 339)                      col_sel = 2'd0;
        else if (x_ext >= 344 && x_ext <= 679)  col_sel = 2'd1;
        else if (x_ext >= 684 && x_ext <= 1023) col_sel = 2'd2;
        else                                    col_ok  = 1'b0;
        row_ok  = 1'b1;
        row_sel = 2'd0;
        if (y_ext <= 251)                      row_sel = 2'd0;
        else if (y_ext >= 256 && y_ext <= 507)  row_sel = 2'd1;
        else if (y_ext >= 512 && y_ext <= 767)  row_sel = 2'd2;
        else                                    row_ok  = 1'b0;
        dec_idx = {2'b00, row_sel} * 4'd3 + {2'b00, col_sel};
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_line
            assign line_blue[gi]   = ((square_q & LINES[gi]) == LINES[gi]) &&
                                     ((color_q & LINES[gi]) == 9'd0);
            assign line_yellow[gi] = ((square_q & LINES[gi]) == LINES[gi]) &&
                                     ((color_q & LINES[gi]) == LINES[gi]);
        end
    endgenerate

    assign blue_win   = |line_blue;
    assign yellow_win = |line_yellow;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        idx_d       = idx_q;
        square_d    = square_q;
        color_d     = color_q;
        turn_d      = turn_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        if (new_game) begin
            state_d     = IDLE;
            square_d    = 9'd0;
            color_d     = 9'd0;
            turn_d      = FIRST_PLAYER;
            game_over_d = 1'b0;
            winner_d    = 2'b00;
        end else if (!start_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                // A finished board stays finished until new_game.
                IDLE:       state_d = game_over_q ? OVER : WAIT_CLICK;
                WAIT_CLICK: if (accept) begin
                    state_d = DECODE;
                    x_d     = mouse_xpos;
                    y_d     = mouse_ypos;
                end
                DECODE: begin
                    if (col_ok && row_ok && !square_q[dec_idx]) begin
                        idx_d   = dec_idx;
                        state_d = PLACE;
                    end else begin
                        state_d = WAIT_CLICK;
                    end
                end
                PLACE: begin
                    square_d[idx_q] = 1'b1;
                    color_d[idx_q]  = turn_q;
                    turn_d          = ~turn_q;
                    state_d         = CHECK;
                end
                CHECK: begin
                    if (blue_win || yellow_win || (&square_q)) begin
                        game_over_d = 1'b1;
                        winner_d    = yellow_win ? 2'b10 : (blue_win ? 2'b01 : 2'b11);
                        state_d     = OVER;
                    end else begin
                        state_d = WAIT_CLICK;
                    end
                end
                OVER:    state_d = OVER;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            mouse_left_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            idx_q        <= 4'd0;
            square_q     <= 9'd0;
            color_q      <= 9'd0;
            turn_q       <= FIRST_PLAYER;
            game_over_q  <= 1'b0;
            winner_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            mouse_left_q <= mouse_left_d;
            x_q          <= x_d;
            y_q          <= y_d;
            idx_q        <= idx_d;
            square_q     <= square_d;
            color_q      <= color_d;
            turn_q       <= turn_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
        end
    end

    assign square       = square_q;
    assign square_color = color_q;
    assign turn         = turn_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule
